// File: rtl/vedic_mul16_seq.sv
// Sequential 16x16 unsigned multiplier: one 8x8 Vedic core, four partial products.
// Optional VEDIC_MUL16_SEQ_ZERO_SKIP_EN: zero operand jumps straight to DONE.

module vedic_mul_2bits (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);
  logic c;
  assign c    = a[1] & b[0] & a[0] & b[1];
  assign p[0] = a[0] & b[0];
  assign p[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
  assign p[2] = (a[1] & b[1]) ^ c;
  assign p[3] = a[1] & b[1] & c;
endmodule

module vedic_mul_4bits (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  logic [3:0] q0, q1, q2, q3;

  vedic_mul_2bits u_q0 (.a(a[1:0]), .b(b[1:0]), .p(q0));
  vedic_mul_2bits u_q1 (.a(a[3:2]), .b(b[1:0]), .p(q1));
  vedic_mul_2bits u_q2 (.a(a[1:0]), .b(b[3:2]), .p(q2));
  vedic_mul_2bits u_q3 (.a(a[3:2]), .b(b[3:2]), .p(q3));

  assign p = {4'b0, q0}
           + {2'b0, q1, 2'b0}
           + {2'b0, q2, 2'b0}
           + {q3, 4'b0};
endmodule

module vedic_mul_unsigned_8bits (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);
  logic [7:0] q0, q1, q2, q3;

  vedic_mul_4bits u_q0 (.a(a[3:0]), .b(b[3:0]), .p(q0));
  vedic_mul_4bits u_q1 (.a(a[7:4]), .b(b[3:0]), .p(q1));
  vedic_mul_4bits u_q2 (.a(a[3:0]), .b(b[7:4]), .p(q2));
  vedic_mul_4bits u_q3 (.a(a[7:4]), .b(b[7:4]), .p(q3));

  assign p = {8'b0, q0}
           + {4'b0, q1, 4'b0}
           + {4'b0, q2, 4'b0}
           + {q3, 8'b0};
endmodule

module vedic_mul16_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] z,
  output logic        busy
);
  typedef enum logic [2:0] {
    IDLE, PP0, PP1, PP2, PP3, DONE
  } state_t;

  state_t      state;
  logic [15:0] a_q, b_q;
  logic [31:0] acc;
  logic [7:0]  m_a, m_b;
  logic [15:0] m_p;
  logic [31:0] pp_term;
  logic        accept;
  logic        zero_op;

  vedic_mul_unsigned_8bits u_core (
    .a(m_a),
    .b(m_b),
    .p(m_p)
  );

`ifdef VEDIC_MUL16_SEQ_ZERO_SKIP_EN
  assign zero_op = (a == 16'd0) || (b == 16'd0);
`else
  assign zero_op = 1'b0;
`endif

  // Outputs are masked by rst so nothing leaks while reset is held.
  assign in_ready  = (state == IDLE) && !rst;
  assign busy      = (state != IDLE) && !rst;
  assign out_valid = (state == DONE) && !rst;
  assign z         = out_valid ? acc : 32'd0;
  assign accept    = in_valid && in_ready;

  always_comb begin
    m_a     = 8'd0;
    m_b     = 8'd0;
    pp_term = 32'd0;
    unique case (state)
      PP0: begin
        m_a     = a_q[7:0];
        m_b     = b_q[7:0];
        pp_term = {16'd0, m_p};
      end
      PP1: begin
        m_a     = a_q[7:0];
        m_b     = b_q[15:8];
        pp_term = {8'd0, m_p, 8'd0};
      end
      PP2: begin
        m_a     = a_q[15:8];
        m_b     = b_q[7:0];
        pp_term = {8'd0, m_p, 8'd0};
      end
      PP3: begin
        m_a     = a_q[15:8];
        m_b     = b_q[15:8];
        pp_term = {m_p, 16'd0};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= 32'd0;
      a_q   <= 16'd0;
      b_q   <= 16'd0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          a_q   <= a;
          b_q   <= b;
          acc   <= 32'd0;
          state <= zero_op ? DONE : PP0;
        end
        PP0: begin
          acc   <= acc + pp_term;
          state <= PP1;
        end
        PP1: begin
          acc   <= acc + pp_term;
          state <= PP2;
        end
        PP2: begin
          acc   <= acc + pp_term;
          state <= PP3;
        end
        PP3: begin
          acc   <= acc + pp_term;
          state <= DONE;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vedic_mul16_seq.sv
// Scoreboard bench for vedic_mul16_seq: directed jobs, latency and handshake checks.
// Expects zero-skip latency when VEDIC_MUL16_SEQ_ZERO_SKIP_EN is defined.
`timescale 1ns/1ps

module tb_vedic_mul16_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] z;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];

`ifdef VEDIC_MUL16_SEQ_ZERO_SKIP_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 5;
`endif

  vedic_mul16_seq dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .z(z),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
    end
  endtask

  // Monitor: pops on each handshake, checks hold stability and idle z.
  logic        prev_hold = 1'b0;
  logic [31:0] prev_z    = 32'd0;
  always @(negedge clk) begin
    if (rst !== 1'b0) begin
      prev_hold <= 1'b0;
    end else begin
      if (out_valid !== 1'b1) check("z_idle_zero", z, 32'd0);
      if (out_valid === 1'b1 && prev_hold)
        check("z_hold_stable", z, prev_z);
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", z, 32'hxxxx_xxxx);
        end else begin
          check("product", z, exp_q.pop_front());
        end
      end
      prev_hold <= (out_valid === 1'b1) && (out_ready !== 1'b1);
      prev_z    <= z;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one job; hold: cycles out_ready stays low after out_valid;
  // pulse_at: cycle (after accept) at which a stray 2*3 pair is driven.
  task automatic run_job(input logic [15:0] ja,
                         input logic [15:0] jb,
                         input logic [31:0] want,
                         input int          want_lat,
                         input int          hold,
                         input int          pulse_at);
    int lat;
    int busy_cnt;
    out_ready = (hold == 0);
    check("in_ready_pre", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    a = ja;
    b = jb;
    exp_q.push_back(want);
    step();
    in_valid = 1'b0;
    lat = 1;
    busy_cnt = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      if (busy === 1'b1) busy_cnt++;
      if (lat == pulse_at) begin
        in_valid = 1'b1;
        a = 16'h0002;
        b = 16'h0003;
      end
      step();
      in_valid = 1'b0;
      lat++;
    end
    if (busy === 1'b1) busy_cnt++;
    check("latency", lat, want_lat);
    check("busy_cycles", busy_cnt, want_lat);
    for (int i = 0; i < hold; i++) begin
      step();
      check("valid_hold", {31'd0, out_valid}, 32'd1);
      if (i == hold - 1) out_ready = 1'b1;
    end
    if (hold > 0) step();
    step();
    check("valid_drop", {31'd0, out_valid}, 32'd0);
    check("in_ready_post", {31'd0, in_ready}, 32'd1);
    check("busy_post", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 16'd0;
    b         = 16'd0;
    step();
    step();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_z", z, 32'd0);
    rst = 1'b0;
    #1;
    check("first_in_ready", {31'd0, in_ready}, 32'd1);

    run_job(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 5, 0, 0);
    run_job(16'h1234, 16'h5678, 32'h0626_0060, 5, 0, 0);
    run_job(16'h00FF, 16'h0100, 32'h0000_FF00, 5, 3, 0);
    run_job(16'h1234, 16'h5678, 32'h0626_0060, 5, 0, 2);
    run_job(16'h8001, 16'h0003, 32'h0001_8003, 5, 0, 0);
    run_job(16'hABCD, 16'h0001, 32'h0000_ABCD, 5, 1, 0);

    // Abort a job in PP2 with a one-cycle reset.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = 16'h1234;
    b = 16'h5678;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_z", z, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    run_job(16'h0003, 16'h0005, 32'h0000_000F, 5, 0, 0);

    run_job(16'h0000, 16'hABCD, 32'd0, ZLAT, 0, 0);
    run_job(16'h1234, 16'h0000, 32'd0, ZLAT, 0, 0);

    repeat (10) step();
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
